// File: rtl/alu_scalar_issue.sv
// alu_scalar_issue: initiator-side front end for the scalar ALU.
// Requests come in over a valid/ready handshake. The operands and the select
// code are registered onto the ALU inputs and held for SETTLE_CYCLES. The
// ALU result and flags are then captured into a registered response, which
// has its own valid/ready handshake.
// Optional feature: define ALU_ISSUE_DIVZERO_EN to intercept div/mod by zero.
// An intercepted operation returns zero with rsp_err set.
module alu_scalar_issue #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [2:0]           req_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_sel,
  input  logic [WIDTH-1:0]     alu_c,
  input  logic [3:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_c,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t     state, state_nx;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       consume;

  // Handshake status. req_ready is also gated by rst_n so that a request
  // cannot appear accepted while the block is held in reset.
  always_comb begin
    req_ready = (state == IDLE) && rst_n;
    busy      = (state != IDLE);
    accept    = req_valid && req_ready;
    capture   = (state == SETTLE) && (settle_cnt == 4'd0);
    consume   = (state == HOLD) && rsp_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: IDLE -> SETTLE on accept, SETTLE -> HOLD on capture, HOLD -> IDLE on handoff.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)  state_nx = SETTLE;
      SETTLE:  if (capture) state_nx = HOLD;
      HOLD:    if (consume) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ALU input drive registers. These change only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      alu_a   <= req_a;
      alu_b   <= req_b;
      alu_sel <= req_op;
    end
  end

  // Settle counter. It is loaded on accept and counts down to the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   settle_cnt <= '0;
    else if (accept)                              settle_cnt <= SETTLE_LOAD;
    else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 4'd1;
  end

`ifdef ALU_ISSUE_DIVZERO_EN
  logic divzero;

  // Record at acceptance whether the operation is a div/mod by zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      divzero <= 1'b0;
    else if (accept) divzero <= ((req_op == 3'd5) || (req_op == 3'd6)) && (req_b == '0);
  end

  // Response capture. A div/mod by zero replaces the ALU output with zero and
  // sets rsp_err. rsp_err stays set until the next operation is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_c     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else if (capture) begin
      rsp_c     <= divzero ? '0 : alu_c;
      rsp_flags <= divzero ? 4'b0000 : alu_flags;
      rsp_err   <= divzero;
    end else if (accept) begin
      rsp_err   <= 1'b0;
    end
  end
`else
  // Response capture of the ALU result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_c     <= '0;
      rsp_flags <= '0;
    end else if (capture) begin
      rsp_c     <= alu_c;
      rsp_flags <= alu_flags;
    end
  end

  assign rsp_err = 1'b0;
`endif

  // Response valid flag and completed-operation counter. The counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      ops_done  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
    end else if (consume) begin
      rsp_valid <= 1'b0;
      ops_done  <= ops_done + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_scalar_issue.sv
// Self-checking bench for alu_scalar_issue. An ALU stand-in drives alu_c and
// alu_flags; its outputs are corrupt until the inputs have been stable long
// enough. Expected responses come from a plain arithmetic reference.
module tb_alu_scalar_issue;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [2:0]    req_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_sel;
  logic [W-1:0]  alu_c;
  logic [3:0]    alu_flags;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_c;
  logic [3:0]    rsp_flags;
  logic          rsp_err;
  logic          busy;
  logic [CW-1:0] ops_done;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_done = 0;

  alu_scalar_issue #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_c(alu_c), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU function.
  function automatic logic [W-1:0] ref_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return '0;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a * b;
      3'd5:    return (b == 0) ? '1 : a / b;
      3'd6:    return (b == 0) ? a : a % b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [W-1:0] c);
    return {c[W-1], (c == 0), c[0], ^c};
  endfunction

  // ALU stand-in: the output is wrong until the inputs have been stable for S-1 edges.
  int unsigned  stable = 0;
  logic [W*2+2:0] prev_in;
  always @(posedge clk) begin
    #1;
    if ({alu_a, alu_b, alu_sel} !== prev_in) begin
      prev_in = {alu_a, alu_b, alu_sel};
      stable  = 0;
    end else if (stable < 1000) begin
      stable = stable + 1;
    end
  end

  always_comb begin
    alu_c     = ref_c(alu_a, alu_b, alu_sel);
    alu_flags = ref_flags(alu_c);
    if (stable < S - 1) begin
      alu_c     = ~alu_c;
      alu_flags = ~alu_flags;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation, starting in IDLE at a negedge. hold gives the
  // number of backpressure cycles; during those cycles a conflicting
  // request is presented.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int hold);
    logic [W-1:0] ec;
    logic [3:0]   ef;
    logic         ee;
    ec = ref_c(a, b, op);
    ef = ref_flags(ec);
    ee = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_EN
    if ((op == 3'd5 || op == 3'd6) && b == 0) begin
      ec = '0;
      ef = 4'b0000;
      ee = 1'b1;
    end
`endif
    check("req_ready_idle", 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
    check("alu_a_reg", 64'(alu_a), 64'(a));
    check("alu_b_reg", 64'(alu_b), 64'(b));
    check("alu_sel_reg", 64'(alu_sel), 64'(op));
    check("busy_settle", 64'(busy), 64'(1'b1));
    check("req_ready_busy", 64'(req_ready), 64'(1'b0));
    check("rsp_valid_early", 64'(rsp_valid), 64'(1'b0));
    for (int i = 1; i < S; i++) begin
      @(negedge clk);
      check("rsp_valid_early", 64'(rsp_valid), 64'(1'b0));
    end
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(1'b1));
    check("rsp_c", 64'(rsp_c), 64'(ec));
    check("rsp_flags", 64'(rsp_flags), 64'(ef));
    check("rsp_err", 64'(rsp_err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_a = ~a; req_b = ~b; req_op = ~op;
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'(1'b1));
      check("hold_c", 64'(rsp_c), 64'(ec));
      check("hold_req_ready", 64'(req_ready), 64'(1'b0));
      check("hold_alu_a", 64'(alu_a), 64'(a));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    exp_done = (exp_done + 1) % (1 << CW);
    check("handoff_valid", 64'(rsp_valid), 64'(1'b0));
    check("ops_done", 64'(ops_done), 64'(exp_done));
    check("handoff_req_ready", 64'(req_ready), 64'(1'b1));
    check("handoff_busy", 64'(busy), 64'(1'b0));
    check("handoff_alu_a", 64'(alu_a), 64'(a));
  endtask

  initial begin
    logic [2:0]   sweep_ops [6];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0]   rop;
    sweep_ops = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1'b0));
    check("rst_alu_sel", 64'(alu_sel), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("rst_ops_done", 64'(ops_done), 64'(0));
    check("rst_rsp_c", 64'(rsp_c), 64'(0));
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 64'(req_ready), 64'(1'b1));
    check("post_rst_busy", 64'(busy), 64'(1'b0));
    @(negedge clk);

    // Add, then the back-to-back op sweep and a backpressured subtract.
    run_op(32'd10, 32'd2, 3'd2, 0);
    check("add_c_const", 64'(rsp_c), 64'(12));
    foreach (sweep_ops[i]) run_op(32'd10, 32'd2, sweep_ops[i], 0);
    check("sweep_ops_done", 64'(ops_done), 64'(7));
    run_op(32'd10, 32'd2, 3'd3, 5);
    check("bp_c_const", 64'(rsp_c), 64'(8));

    // Divide by zero.
    run_op(32'd10, 32'd0, 3'd5, 0);

    // Reset during SETTLE: the operation is discarded.
    req_valid = 1'b1; req_a = 32'd10; req_b = 32'd2; req_op = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_done = 0;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("midrst_alu_sel", 64'(alu_sel), 64'(0));
    check("midrst_alu_a", 64'(alu_a), 64'(0));
    check("midrst_ops_done", 64'(ops_done), 64'(0));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < S + 3; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 64'(rsp_valid), 64'(1'b0));
    end
    check("midrst_ops_after", 64'(ops_done), 64'(0));

    // Randomized operations. These run long enough to wrap ops_done.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) rb = $urandom;
      run_op(ra, rb, rop, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time limit, so that a stuck run still produces a summary.
  initial begin
    #200000;
    n_fails++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
